// File: rtl/sdram_sched_pkg.sv
// rtl/sdram_sched_pkg.sv - shared types for the SDRAM port 0 scheduler
package sdram_sched_pkg;
    localparam int SCHED_ADDR_WIDTH = 25;
    localparam int WDOG_WIDTH       = 10;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_BURST,
        RD_END
    } sched_state_t;

    typedef struct packed {
        logic [SCHED_ADDR_WIDTH-1:0] addr;
        logic [15:0]                 data;
    } wr_entry_t;
endpackage

// File: rtl/sdram_port_scheduler_if.sv
// rtl/sdram_port_scheduler_if.sv - loader, video and SDRAM port 0 signals of the scheduler
interface sdram_port_scheduler_if #(
    parameter int ADDR_WIDTH = 25
);
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [15:0]           wr_data;
    logic                  wr_ready;
    logic                  wr_overflow;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_end_burst;
    logic                  rd_granted;
    logic                  rd_data_available;
    logic [15:0]           rd_data;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_data;
    logic                  mem_wr_req;
    logic                  mem_rd_req;
    logic                  mem_end_burst_req;
    logic                  mem_busy;
    logic                  mem_data_available;
    logic [15:0]           mem_q;

    // master: requesters plus controller model; slave: the scheduler itself
    modport master (
        output wr_valid, wr_addr, wr_data, rd_req, rd_addr, rd_end_burst,
               mem_busy, mem_data_available, mem_q,
        input  wr_ready, wr_overflow, rd_granted, rd_data_available, rd_data,
               mem_addr, mem_data, mem_wr_req, mem_rd_req, mem_end_burst_req
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, rd_end_burst,
               mem_busy, mem_data_available, mem_q,
        output wr_ready, wr_overflow, rd_granted, rd_data_available, rd_data,
               mem_addr, mem_data, mem_wr_req, mem_rd_req, mem_end_burst_req
    );
endinterface

// File: rtl/sched_wr_fifo.sv
// rtl/sched_wr_fifo.sv - loader write queue holding {addr, data} entries
module sched_wr_fifo
    import sdram_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  wr_entry_t     push_entry,
    input  logic          pop,
    output wr_entry_t     head,
    output logic [PTR_W:0] count,
    output logic          full,
    output logic          empty
);
    wr_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so push-while-full is legal alongside it
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/sdram_port_scheduler.sv
// rtl/sdram_port_scheduler.sv - arbitrates SDRAM port 0 between queued loader writes and video bursts
module sdram_port_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int ADDR_WIDTH    = SCHED_ADDR_WIDTH,
    parameter int BURST_TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sdram_port_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    sched_state_t          state;
    wr_entry_t             push_entry;
    wr_entry_t             head;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [WDOG_WIDTH-1:0] wdog;
    logic                  wdog_hit;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           data_q;
    logic                  wr_req_q;
    logic                  rd_req_q;
    logic                  end_req_q;
    logic                  granted_q;
    logic                  overflow_q;

    assign push_entry.addr = bus.wr_addr;
    assign push_entry.data = bus.wr_data;
    assign push            = bus.wr_valid && !fifo_full;
    assign pop             = (state == WR_ISSUE) && !bus.mem_busy && !fifo_empty;

    sched_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Fires on the cycle whose edge would bring the watchdog up to the timeout
    assign wdog_hit = (32'(wdog) + 32'd1) >= 32'(BURST_TIMEOUT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            end_req_q <= 1'b0;
            granted_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            wdog      <= '0;
        end else begin
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            end_req_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_full)              state <= WR_ISSUE;
                    else if (bus.rd_req)        state <= RD_ISSUE;
                    else if (fifo_count != '0)  state <= WR_ISSUE;
                end
                WR_ISSUE: if (!bus.mem_busy) begin
                    wr_req_q <= 1'b1;
                    addr_q   <= head.addr;
                    data_q   <= head.data;
                    state    <= WR_WAIT;
                end
                WR_WAIT: if (!bus.mem_busy) state <= IDLE;
                RD_ISSUE: if (!bus.mem_busy) begin
                    rd_req_q  <= 1'b1;
                    addr_q    <= bus.rd_addr;
                    granted_q <= 1'b1;
                    wdog      <= '0;
                    state     <= RD_BURST;
                end
                RD_BURST: begin
                    if (bus.rd_end_burst || wdog_hit) begin
                        end_req_q <= 1'b1;
                        state     <= RD_END;
                    end else if (wdog != '1) begin
                        wdog <= wdog + WDOG_WIDTH'(1);
                    end
                end
                RD_END: begin
                    granted_q <= 1'b0;
                    if (!bus.mem_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                      overflow_q <= 1'b0;
        else if (bus.wr_valid && fifo_full) overflow_q <= 1'b1;
    end

    assign bus.wr_ready          = !fifo_full;
    assign bus.wr_overflow       = overflow_q;
    assign bus.rd_granted        = granted_q;
    assign bus.rd_data_available = bus.mem_data_available && granted_q;
    assign bus.rd_data           = bus.mem_q;
    assign bus.mem_addr          = addr_q;
    assign bus.mem_data          = data_q;
    assign bus.mem_wr_req        = wr_req_q;
    assign bus.mem_rd_req        = rd_req_q;
    assign bus.mem_end_burst_req = end_req_q;
endmodule

// File: tb/tb_sdram_port_scheduler.sv
// tb/tb_sdram_port_scheduler.sv - randomized and directed bench with a queue-based scheduler model
module tb_sdram_port_scheduler;
    localparam int AW    = 25;
    localparam int DEPTH = 4;
    localparam int TMO   = 1023;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sdram_port_scheduler_if #(.ADDR_WIDTH(AW)) bus ();

    sdram_port_scheduler #(
        .FIFO_DEPTH    (DEPTH),
        .ADDR_WIDTH    (AW),
        .BURST_TIMEOUT (TMO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner of the port and a queue of pending loader words
    localparam int M_IDLE = 0, M_WANT_WR = 1, M_WR_FLIGHT = 2, M_WANT_RD = 3, M_BURST = 4, M_CLOSE = 5;
    logic [AW+15:0]  mq[$];
    int              m_stage;
    bit              m_full;
    logic            m_ovf, e_wr, e_rd, e_end, e_gr;
    logic [AW-1:0]   e_addr;
    logic [15:0]     e_data;
    longint          cyc, burst_t0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_stage = M_IDLE;
            m_ovf = 0; e_wr = 0; e_rd = 0; e_end = 0; e_gr = 0;
            e_addr = '0; e_data = '0;
            cyc = 0; burst_t0 = 0;
        end else begin
            cyc++;
            m_full = (mq.size() == DEPTH);
            e_wr = 0; e_rd = 0; e_end = 0;
            if (m_stage == M_CLOSE) e_gr = 0;
            case (m_stage)
                M_IDLE: m_stage = m_full ? M_WANT_WR : bus.rd_req ? M_WANT_RD :
                                  (mq.size() != 0) ? M_WANT_WR : M_IDLE;
                M_WANT_WR: if (!bus.mem_busy) begin
                    e_wr = 1;
                    {e_addr, e_data} = mq.pop_front();
                    m_stage = M_WR_FLIGHT;
                end
                M_WR_FLIGHT, M_CLOSE: if (!bus.mem_busy) m_stage = M_IDLE;
                M_WANT_RD: if (!bus.mem_busy) begin
                    e_rd = 1; e_gr = 1; e_addr = bus.rd_addr;
                    burst_t0 = cyc;
                    m_stage = M_BURST;
                end
                M_BURST: if (bus.rd_end_burst || (cyc - burst_t0) == TMO) begin
                    e_end = 1;
                    m_stage = M_CLOSE;
                end
                default: m_stage = M_IDLE;
            endcase
            if (bus.wr_valid) begin
                if (m_full) m_ovf = 1;
                else        mq.push_back({bus.wr_addr, bus.wr_data});
            end
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en && reset_n) begin
            chk("wr_ready",          bus.wr_ready,          mq.size() != DEPTH);
            chk("wr_overflow",       bus.wr_overflow,       m_ovf);
            chk("rd_granted",        bus.rd_granted,        e_gr);
            chk("mem_wr_req",        bus.mem_wr_req,        e_wr);
            chk("mem_rd_req",        bus.mem_rd_req,        e_rd);
            chk("mem_end_burst_req", bus.mem_end_burst_req, e_end);
            chk("mem_addr",          bus.mem_addr,          e_addr);
            chk("mem_data",          bus.mem_data,          e_data);
            chk("rd_data_available", bus.rd_data_available, bus.mem_data_available && e_gr);
            chk("rd_data",           bus.rd_data,           bus.mem_q);
        end
    end

    int ncyc = 0;
    int n_wr = 0;
    always @(posedge clk) ncyc++;
    always @(negedge clk) if (bus.mem_wr_req) n_wr++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [15:0] d);
        bus.wr_valid = 1; bus.wr_addr = a; bus.wr_data = d;
        tick(1);
        bus.wr_valid = 0;
    endtask

    task automatic end_burst();
        bus.rd_end_burst = 1;
        tick(1);
        bus.rd_end_burst = 0;
    endtask

    // mask bits: 0 mem_wr_req, 1 mem_rd_req, 2 mem_end_burst_req, 3 rd_granted
    task automatic wait_sig(input logic [3:0] mask, input int limit, output int at, output int kind,
                            output logic [AW-1:0] a, output logic [15:0] d);
        logic [3:0] s;
        at = -1; kind = -1; a = '0; d = '0;
        for (int i = 0; i < limit && at < 0; i++) begin
            @(negedge clk);
            s = {bus.rd_granted, bus.mem_end_burst_req, bus.mem_rd_req, bus.mem_wr_req} & mask;
            if (s != 4'b0) begin
                at = ncyc; a = bus.mem_addr; d = bus.mem_data;
                for (int b = 3; b >= 0; b--) if (s[b]) kind = b;
            end
        end
        tick(1);
    endtask

    initial begin
        #700000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int at, kind, c0, w0;
        logic [AW-1:0] a;
        logic [15:0] d;
        bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req = 0; bus.rd_addr = '0; bus.rd_end_burst = 0;
        bus.mem_busy = 0; bus.mem_data_available = 0; bus.mem_q = '0;
        tick(3);
        chk("rst_rd_granted",  bus.rd_granted, 0);
        chk("rst_wr_ready",    bus.wr_ready, 1);
        chk("rst_wr_overflow", bus.wr_overflow, 0);
        chk("rst_mem_addr",    bus.mem_addr, 0);
        chk("rst_mem_data",    bus.mem_data, 0);
        chk("rst_reqs",        {bus.mem_wr_req, bus.mem_rd_req, bus.mem_end_burst_req}, 0);
        reset_n = 1; chk_en = 1;
        tick(2);

        // Single write while idle
        c0 = ncyc;
        push_wr(25'h100, 16'hBEEF);
        chk("t2_wr_ready", bus.wr_ready, 1);
        wait_sig(4'b0001, 20, at, kind, a, d);
        chk("t2_latency", at - c0, 3);
        chk("t2_addr", a, 25'h100);
        chk("t2_data", d, 16'hBEEF);
        tick(5);

        // Writes queued during a burst wait for its end, then drain in order
        bus.rd_addr = 25'h4000; bus.rd_req = 1;
        wait_sig(4'b0010, 20, at, kind, a, d);
        bus.rd_req = 0;
        chk("t3_rd_addr", a, 25'h4000);
        for (int i = 0; i < 3; i++) push_wr(AW'(32'h200 + i), 16'(32'h1110 + i));
        w0 = n_wr;
        tick(10);
        chk("t3_no_wr_in_burst", n_wr - w0, 0);
        chk("t3_granted", bus.rd_granted, 1);
        end_burst();
        for (int i = 0; i < 3; i++) begin
            wait_sig(4'b0001, 30, at, kind, a, d);
            chk("t3_wr_order_addr", a, AW'(32'h200 + i));
            chk("t3_wr_order_data", d, 16'(32'h1110 + i));
        end
        tick(5);

        // One queued write versus a pending read: the read wins
        bus.rd_addr = 25'h5000; bus.rd_req = 1;
        wait_sig(4'b0010, 20, at, kind, a, d);
        bus.rd_req = 0;
        push_wr(25'h300, 16'h3333);
        bus.rd_addr = 25'h6000; bus.rd_req = 1;
        end_burst();
        wait_sig(4'b0011, 30, at, kind, a, d);
        bus.rd_req = 0;
        chk("t4a_first_kind", kind, 1);
        chk("t4a_first_addr", a, 25'h6000);
        end_burst();
        wait_sig(4'b0011, 30, at, kind, a, d);
        chk("t4a_second_kind", kind, 0);
        chk("t4a_second_addr", a, 25'h300);
        tick(5);

        // Full queue versus a pending read: the starvation guard lets a write through first
        bus.rd_addr = 25'h7000; bus.rd_req = 1;
        wait_sig(4'b0010, 20, at, kind, a, d);
        bus.rd_req = 0;
        for (int i = 0; i < 4; i++) push_wr(AW'(32'h400 + i), 16'(32'h4440 + i));
        chk("t4b_full_ready", bus.wr_ready, 0);
        bus.rd_addr = 25'h8000; bus.rd_req = 1;
        end_burst();
        wait_sig(4'b0011, 30, at, kind, a, d);
        chk("t4b_first_kind", kind, 0);
        chk("t4b_first_addr", a, 25'h400);
        wait_sig(4'b0011, 30, at, kind, a, d);
        bus.rd_req = 0;
        chk("t4b_second_kind", kind, 1);
        chk("t4b_second_addr", a, 25'h8000);
        end_burst();
        tick(30);

        // Overflow with the controller stuck busy
        bus.mem_busy = 1;
        w0 = n_wr;
        for (int i = 0; i < 5; i++) begin
            bus.wr_valid = 1; bus.wr_addr = AW'(32'h500 + i); bus.wr_data = 16'(32'h5550 + i);
            tick(1);
            if (i == 2) chk("t5_ready_after_3", bus.wr_ready, 1);
            if (i == 3) begin
                chk("t5_ready_after_4", bus.wr_ready, 0);
                chk("t5_ovf_after_4", bus.wr_overflow, 0);
            end
            if (i == 4) chk("t5_ovf_after_5", bus.wr_overflow, 1);
        end
        bus.wr_valid = 0;
        tick(3);
        bus.mem_busy = 0;
        tick(30);
        chk("t5_ovf_sticky", bus.wr_overflow, 1);
        chk("t5_drained_count", n_wr - w0, 4);
        chk("t5_ready_again", bus.wr_ready, 1);

        // Watchdog ends an abandoned burst
        bus.rd_addr = 25'h9000; bus.rd_req = 1;
        wait_sig(4'b0010, 20, c0, kind, a, d);
        bus.rd_req = 0;
        wait_sig(4'b0100, 1100, at, kind, a, d);
        chk("t6_wdog_cycles", at - c0, TMO);
        chk("t6_granted_falls", bus.rd_granted, 0);
        tick(5);

        // Reset in the middle of a burst with writes queued
        bus.rd_addr = 25'hA000; bus.rd_req = 1;
        wait_sig(4'b0010, 20, at, kind, a, d);
        bus.rd_req = 0;
        push_wr(25'h600, 16'h6666);
        push_wr(25'h601, 16'h6667);
        tick(3);
        #2;
        reset_n = 0;
        #1;
        chk("t7_granted", bus.rd_granted, 0);
        chk("t7_wr_ready", bus.wr_ready, 1);
        chk("t7_overflow", bus.wr_overflow, 0);
        chk("t7_mem_addr", bus.mem_addr, 0);
        chk("t7_reqs", {bus.mem_wr_req, bus.mem_rd_req, bus.mem_end_burst_req}, 0);
        tick(2);
        reset_n = 1;
        w0 = n_wr;
        tick(20);
        chk("t7_fifo_discarded", n_wr - w0, 0);
        c0 = ncyc;
        bus.rd_addr = 25'hB000; bus.rd_req = 1;
        wait_sig(4'b0010, 20, at, kind, a, d);
        bus.rd_req = 0;
        chk("t7_new_burst_latency", at - c0, 2);
        chk("t7_new_burst_addr", a, 25'hB000);
        end_burst();
        tick(5);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            bus.mem_busy           = ($urandom_range(0, 99) < 30);
            bus.mem_data_available = 1'($urandom_range(0, 1));
            bus.mem_q              = 16'($urandom);
            bus.wr_valid           = ($urandom_range(0, 99) < 25);
            bus.wr_addr            = AW'($urandom);
            bus.wr_data            = 16'($urandom);
            if (bus.rd_req && bus.mem_rd_req) bus.rd_req = 0;
            else if (!bus.rd_req && $urandom_range(0, 99) < 10) begin
                bus.rd_req  = 1;
                bus.rd_addr = AW'($urandom);
            end
            bus.rd_end_burst = ($urandom_range(0, 99) < (bus.rd_granted ? 8 : 2));
            tick(1);
        end
        bus.wr_valid = 0; bus.rd_req = 0; bus.rd_end_burst = 0; bus.mem_busy = 0;
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sdram_port_scheduler.md
# sdram_port_scheduler

Schedules the single SDRAM burst port between two requesters: ROM/image loader word writes and video burst reads. It replaces the combinational address/request mux in front of `sdram_burst` port 0. Loader writes are queued in a small FIFO so that download traffic never corrupts an in-flight video burst. Video reads get priority, with a write-starvation guard and a burst watchdog.

## Interface
- `FIFO_DEPTH`, 4: loader write queue entries (power of two, ≥2).
- `ADDR_WIDTH`, 25: SDRAM word address width.
- `BURST_TIMEOUT`, 1023: max cycles a read burst may hold the port before forced end.
- `clk`  in  1  system clock (131.072 MHz domain).
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  loader write word present.
- `wr_addr`  in  ADDR_WIDTH  loader word address.
- `wr_data`  in  16  loader word.
- `wr_ready`  out  1  FIFO not full; a write is accepted when `wr_valid && wr_ready`.
- `wr_overflow`  out  1  sticky; set when `wr_valid` arrives while full; cleared only by reset.
- `rd_req`  in  1  video requests a burst (level, held until `rd_granted`).
- `rd_addr`  in  ADDR_WIDTH  burst start address, stable while `rd_req`.
- `rd_end_burst`  in  1  video ends the current burst (1-cycle pulse).
- `rd_granted`  out  1  high from burst issue through burst end.
- `rd_data_available`  out  1  `mem_data_available` gated by `rd_granted`.
- `rd_data`  out  16  `mem_q` passthrough.
- `mem_addr`  out  ADDR_WIDTH  to `p0_addr`.
- `mem_data`  out  16  to `p0_data`.
- `mem_wr_req`, `mem_rd_req`, `mem_end_burst_req`  out  1  to `p0_*_req`; 1-cycle pulses.
- `mem_busy`  in  1  controller busy; commands issue only when low.
- `mem_data_available`  in  1  from `p0_data_available`.
- `mem_q`  in  16  from `p0_q`.

## Operation
- FIFO holds {addr, data}. Push on accept; pop when the write is issued. Simultaneous push and pop while full is allowed; the count is unchanged.
- The FSM has the following states: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_BURST, RD_END.
- IDLE selects the next requester:
  - FIFO full → WR_ISSUE (starvation guard).
  - Else `rd_req` → RD_ISSUE.
  - Else FIFO not empty → WR_ISSUE.
  - Else stay in IDLE.
- WR_ISSUE:
  - Wait for `!mem_busy`.
  - Then pulse `mem_wr_req` with the FIFO head on `mem_addr`/`mem_data`, pop, and go to WR_WAIT.
- WR_WAIT: hold 1 cycle minimum, then wait for `!mem_busy` → IDLE.
- RD_ISSUE: wait for `!mem_busy`, then pulse `mem_rd_req` with `rd_addr`, set `rd_granted`, and go to RD_BURST.
- RD_BURST:
  - `rd_end_burst`, or the watchdog reaching `BURST_TIMEOUT` → pulse `mem_end_burst_req` and go to RD_END.
  - Watchdog: 10-bit counter, cleared on RD_ISSUE exit, saturates.
- RD_END: clear `rd_granted`, wait for `!mem_busy` → IDLE.
- `mem_addr` is registered, and holds the last issued value between commands.
- An `rd_end_burst` arriving outside RD_BURST is ignored.

## Timing
- Reset values:
  - `rd_granted`, `mem_*_req` = 0.
  - `mem_addr`, `mem_data` = 0.
  - `wr_ready` = 1, `wr_overflow` = 0.
  - FIFO empty, FSM in IDLE, watchdog 0.
- All request outputs are registered. From IDLE with `mem_busy` low, the request pulse appears 2 cycles after the decision edge (IDLE → ISSUE → pulse).
- Write accept to `mem_wr_req`: 3 cycles minimum when idle and empty.
- `rd_data_available`/`rd_data` are combinational (0 latency from `mem_*`).
- Reset asserted mid-burst: all outputs return to reset values immediately and the FIFO contents are discarded. The controller is reset separately and is not signalled.
- `wr_ready` deasserts in the same cycle the count reaches `FIFO_DEPTH`.

## Structure
- Add a shared package `sdram_sched_pkg` containing:
  - the `sched_state_t` enum;
  - a packed `wr_entry_t` {addr, data}.
- One sub-module, `sched_wr_fifo`: a synchronous FIFO with count, full, and empty flags, using the same async active-low reset.
- The FSM and watchdog live in the top-level module.

## Test plan
- Single write, idle: `wr_valid` with addr 0x100, data 0xBEEF → `mem_wr_req` pulses 3 cycles later with matching `mem_addr`/`mem_data`; `wr_ready` stays 1.
- Burst with queued writes: grant a read at 0x4000, push 3 writes mid-burst → no `mem_wr_req` until after `rd_end_burst`; then 3 writes issue in FIFO order.
- Contention: FIFO holds 1 entry and `rd_req` is high in IDLE → read issues first. Repeat with FIFO full → the write issues first.
- Overflow: 5 pushes with `mem_busy` stuck high → `wr_ready` is 0 after the 4th push; `wr_overflow` is set on the 5th and stays set.
- Watchdog: a burst with no `rd_end_burst` → `mem_end_burst_req` pulses exactly 1023 cycles after the burst enters RD_BURST; `rd_granted` then falls.
- Reset mid-burst: drop `reset_n` during RD_BURST → `rd_granted` = 0 and the FIFO is empty immediately; after release a new burst issues normally.
